// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the RAM arbiter: FSM states, owner codes and
// the default starvation threshold.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_D    = 2'd1,
        OWN_F    = 2'd2,
        OWN_X    = 2'd3
    } owner_t;

    localparam int MAXWAIT_DEFAULT = 4;
    // Wide enough for the largest supported threshold (15).
    localparam int WAITW = 4;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Counts lost arbitrations for one low-priority requester and flags it
// as promoted once the count reaches MAXWAIT.
module starve_counter
    import mem_arbiter_pkg::*;
#(
    parameter int MAXWAIT = MAXWAIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic lost,
    input  logic granted,
    output logic promoted
);

    localparam logic [WAITW-1:0] LIMIT = WAITW'(MAXWAIT);

    logic [WAITW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!req || granted) begin
            cnt <= '0;
        end else if (lost && cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign promoted = (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Three-port arbiter for the single-port instruction/data RAM.
//   state  | meaning
//   IDLE   | pick a winner, register RAM controls and owner
//   ACCESS | RAM controls held, RAM samples them at the closing edge
//   DONE   | owner's ack high for one cycle, rdata from RAM
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int MAXWAIT = MAXWAIT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    input  logic          x_req,
    input  logic          x_we,
    input  logic [AW-1:0] x_addr,
    input  logic [DW-1:0] x_wdata,
    output logic          x_ack,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_write,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner
);

    state_t state, state_nx;
    owner_t owner_q, winner;
    logic   op_we;
    logic   any_req;
    logic   f_promoted, x_promoted;
    logic   f_grant, x_grant, f_lost, x_lost;

    assign any_req = d_req | f_req | x_req;

    // Promotion overrides the fixed D > F > X order; F wins a promotion tie.
    always_comb begin
        winner = OWN_NONE;
        if (f_req && f_promoted) begin
            winner = OWN_F;
        end else if (x_req && x_promoted) begin
            winner = OWN_X;
        end else if (d_req) begin
            winner = OWN_D;
        end else if (f_req) begin
            winner = OWN_F;
        end else if (x_req) begin
            winner = OWN_X;
        end
    end

    assign f_grant = (state == ST_IDLE) && (winner == OWN_F);
    assign x_grant = (state == ST_IDLE) && (winner == OWN_X);
    assign f_lost  = (state == ST_IDLE) && f_req && (winner != OWN_F);
    assign x_lost  = (state == ST_IDLE) && x_req && (winner != OWN_X);

    starve_counter #(.MAXWAIT(MAXWAIT)) u_wait_f (
        .clk      (clk),
        .reset    (reset),
        .req      (f_req),
        .lost     (f_lost),
        .granted  (f_grant),
        .promoted (f_promoted)
    );

    starve_counter #(.MAXWAIT(MAXWAIT)) u_wait_x (
        .clk      (clk),
        .reset    (reset),
        .req      (x_req),
        .lost     (x_lost),
        .granted  (x_grant),
        .promoted (x_promoted)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (any_req) state_nx = ST_ACCESS;
            ST_ACCESS: state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // op_we remembers the direction so DONE knows whether to forward RAM data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_q   <= OWN_NONE;
            op_we     <= 1'b0;
            mem_addr  <= '0;
            mem_write <= 1'b0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    owner_q <= winner;
                    case (winner)
                        OWN_D: begin
                            op_we     <= d_we;
                            mem_addr  <= d_addr;
                            mem_write <= d_we;
                            mem_wdata <= d_we ? d_wdata : '0;
                        end
                        OWN_F: begin
                            op_we     <= 1'b0;
                            mem_addr  <= f_addr;
                            mem_write <= 1'b0;
                            mem_wdata <= '0;
                        end
                        OWN_X: begin
                            op_we     <= x_we;
                            mem_addr  <= x_addr;
                            mem_write <= x_we;
                            mem_wdata <= x_we ? x_wdata : '0;
                        end
                        default: begin
                            op_we     <= 1'b0;
                            mem_addr  <= '0;
                            mem_write <= 1'b0;
                            mem_wdata <= '0;
                        end
                    endcase
                end
                ST_ACCESS: begin
                    mem_write <= 1'b0;
                end
                default: begin
                    owner_q   <= OWN_NONE;
                    op_we     <= 1'b0;
                    mem_addr  <= '0;
                    mem_write <= 1'b0;
                    mem_wdata <= '0;
                end
            endcase
        end
    end

    assign d_ack = (state == ST_DONE) && (owner_q == OWN_D);
    assign f_ack = (state == ST_DONE) && (owner_q == OWN_F);
    assign x_ack = (state == ST_DONE) && (owner_q == OWN_X);
    assign rdata = ((state == ST_DONE) && !op_we) ? mem_rdata : '0;
    assign owner = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: drivers issue requests and push the
// expected acks; a negedge monitor pops and compares each ack.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [7:0]  d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_ack;
    logic        f_req = 1'b0;
    logic [7:0]  f_addr = '0;
    logic        f_ack;
    logic        x_req = 1'b0, x_we = 1'b0;
    logic [7:0]  x_addr = '0;
    logic [15:0] x_wdata = '0;
    logic        x_ack;
    logic [15:0] rdata;
    logic [7:0]  mem_addr;
    logic        mem_write;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [1:0]  owner;

    logic [15:0] ram [256];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [2:0]  acks;
        logic [15:0] rdata;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    logic [45:0] all_out;
    assign all_out = {d_ack, f_ack, x_ack, rdata, mem_addr, mem_write, mem_wdata, owner};

    always #5 clk = ~clk;

    mem_arbiter #(.AW(8), .DW(16), .MAXWAIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_ack     (f_ack),
        .x_req     (x_req),
        .x_we      (x_we),
        .x_addr    (x_addr),
        .x_wdata   (x_wdata),
        .x_ack     (x_ack),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .owner     (owner)
    );

    // RAM: each word preloaded as {addr, addr}, 0x05 overridden to 16'h1234.
    initial begin
        for (int i = 0; i < 256; i++) ram[i] <= {8'(i), 8'(i)};
        ram[5] <= 16'h1234;
    end

    always @(posedge clk) begin
        if (mem_write) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void push(input logic [2:0] acks, input logic [15:0] rd, input int c);
        exp_t e;
        e.acks  = acks;
        e.rdata = rd;
        e.cyc   = c;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if ({d_ack, f_ack, x_ack} != 3'b000) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got acks %b at cycle %0d required none", {d_ack, f_ack, x_ack}, cyc);
            end else begin
                e = exp_q.pop_front();
                check("ack_port", {d_ack, f_ack, x_ack}, e.acks);
                check("ack_rdata", rdata, e.rdata);
                check("ack_cycle", cyc, e.cyc);
                check("done_mem_write", mem_write, 1'b0);
            end
        end
    end

    task automatic req_port(input int p, input logic we, input logic [7:0] a, input logic [15:0] wd);
        case (p)
            1: begin d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; end
            2: begin f_req = 1'b1; f_addr = a; end
            default: begin x_req = 1'b1; x_we = we; x_addr = a; x_wdata = wd; end
        endcase
    endtask

    task automatic drop_port(input int p);
        case (p)
            1: begin d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; end
            2: begin f_req = 1'b0; f_addr = '0; end
            default: begin x_req = 1'b0; x_we = 1'b0; x_addr = '0; x_wdata = '0; end
        endcase
    endtask

    task automatic wait_ack(input int p, input string name);
        int   n = 0;
        logic hit = 1'b0;
        while (!hit && n < 60) begin
            @(negedge clk);
            n++;
            case (p)
                1:       hit = d_ack;
                2:       hit = f_ack;
                default: hit = x_ack;
            endcase
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no ack in 60 cycles required ack", name);
        end
        @(posedge clk);
        #1;
    endtask

    // Call and return #1 after a rising edge; keep leaves req high for a follow-on request.
    task automatic access(input int p, input logic we, input logic [7:0] a,
                          input logic [15:0] wd, input bit keep, input string name);
        req_port(p, we, a, wd);
        wait_ack(p, name);
        if (!keep) drop_port(p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_out, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single fetch of 0x05.
        c = cyc;
        push(3'b010, 16'h1234, c + 2);
        fork
            access(2, 1'b0, 8'h05, 16'h0, 1'b0, "t1_f");
            begin
                @(negedge clk);
                check("t1_idle_owner", owner, 2'd0);
                @(negedge clk);
                check("t1_access", {mem_addr, mem_write, mem_wdata, owner}, {8'h05, 1'b0, 16'h0, 2'd2});
            end
        join
        @(negedge clk);
        check("t1_after_idle", all_out, 0);
        @(posedge clk);
        #1;

        // D write and F fetch collide; D first, F re-granted at cycle 3.
        c = cyc;
        push(3'b100, 16'h0, c + 2);
        push(3'b010, 16'h0101, c + 5);
        fork
            access(1, 1'b1, 8'h20, 16'hBEEF, 1'b0, "t2_d");
            access(2, 1'b0, 8'h01, 16'h0, 1'b0, "t2_f");
            begin
                repeat (2) @(negedge clk);
                check("t2_d_access", {mem_addr, mem_write, mem_wdata, owner}, {8'h20, 1'b1, 16'hBEEF, 2'd1});
                repeat (3) @(negedge clk);
                check("t2_f_access", {mem_addr, mem_write, mem_wdata, owner}, {8'h01, 1'b0, 16'h0, 2'd2});
            end
        join
        check("t2_ram_word", ram[8'h20], 16'hBEEF);
        c = cyc;
        push(3'b100, 16'hBEEF, c + 2);
        access(1, 1'b0, 8'h20, 16'h0, 1'b0, "t2_rb");

        // Back-to-back D reads starve F until promotion at the 5th arbitration.
        c = cyc;
        push(3'b100, 16'h3030, c + 2);
        push(3'b100, 16'h3131, c + 5);
        push(3'b100, 16'h3232, c + 8);
        push(3'b100, 16'h3333, c + 11);
        push(3'b010, 16'h0707, c + 14);
        push(3'b100, 16'h3434, c + 17);
        fork
            begin
                for (int k = 0; k < 5; k++) access(1, 1'b0, 8'(8'h30 + k), 16'h0, (k < 4), "t3_d");
            end
            access(2, 1'b0, 8'h07, 16'h0, 1'b0, "t3_f");
        join

        // Loader write then read-back.
        c = cyc;
        push(3'b001, 16'h0, c + 2);
        push(3'b001, 16'hA5A5, c + 5);
        access(3, 1'b1, 8'h10, 16'hA5A5, 1'b1, "t4_xw");
        access(3, 1'b0, 8'h10, 16'h0, 1'b0, "t4_xr");

        // F re-requests continuously; X held and promoted after 4 losses.
        c = cyc;
        push(3'b010, 16'h4040, c + 2);
        push(3'b010, 16'h4141, c + 5);
        push(3'b010, 16'h4242, c + 8);
        push(3'b010, 16'h4343, c + 11);
        push(3'b001, 16'hA5A5, c + 14);
        push(3'b010, 16'h4444, c + 17);
        fork
            begin
                for (int k = 0; k < 5; k++) access(2, 1'b0, 8'(8'h40 + k), 16'h0, (k < 4), "t5_f");
            end
            access(3, 1'b0, 8'h10, 16'h0, 1'b0, "t5_x");
        join

        // Reset during ACCESS of a D read; held request re-arbitrated afterwards.
        c = cyc;
        push(3'b100, 16'h3030, c + 5);
        fork
            access(1, 1'b0, 8'h30, 16'h0, 1'b0, "t6_d");
            begin
                @(posedge clk);
                #1;
                reset = 1'b0;
                @(negedge clk);
                check("t6_in_access", {mem_addr, owner}, {8'h30, 2'd1});
                @(posedge clk);
                #1;
                @(negedge clk);
                check("t6_reset_outputs", all_out, 0);
                @(posedge clk);
                #1;
                reset = 1'b1;
            end
        join

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
